// File: rtl/multi_channel_monitor.sv
// Debug monitor: selects one of CHANNELS words (manual or auto-cycling),
// snapshots it with optional freeze, and scans it onto a multiplexed hex
// 7-segment display, one digit per nibble.
// Optional build macro: MONITOR_LEADING_ZERO_BLANK_EN blanks the digits above
// the most significant nonzero nibble of the snapshot.
module multi_channel_monitor #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned CHANNELS    = 16,
  parameter int unsigned SCAN_DIV    = 1024,
  parameter int unsigned AUTO_PERIOD = 32'd16777216,
  localparam int unsigned DIGITS     = DATA_WIDTH / 4,
  localparam int unsigned SEL_W      = $clog2(CHANNELS)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [CHANNELS*DATA_WIDTH-1:0] channel_data,
  input  logic [SEL_W-1:0]               select_in,
  input  logic                           mode_auto,
  input  logic                           freeze,
  output logic [SEL_W-1:0]               channel_out,
  output logic [DIGITS-1:0]              digit_enable,
  output logic [7:0]                     segment_out,
  output logic                           frozen_out
);

  localparam int unsigned PRE_W  = $clog2(SCAN_DIV);
  localparam int unsigned AUTO_W = $clog2(AUTO_PERIOD);
  localparam int unsigned DIG_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [SEL_W-1:0]      chan_q, chan_d;
  logic [DATA_WIDTH-1:0] snap_q, snap_d;
  logic [PRE_W-1:0]      pre_q, pre_d;
  logic [DIG_W-1:0]      dig_q, dig_d;
  logic [AUTO_W-1:0]     auto_q, auto_d;
  logic                  frozen_q, frozen_d;
  logic                  mode_q, mode_d;

  logic [DATA_WIDTH-1:0] sel_word_c;
  logic [3:0]            nibble_c;
  logic                  lz_blank_c;
  logic [6:0]            hex_c;

  // Hex digit to a..g segment pattern
  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  // Mux the active channel's word out of the flat bus
  always_comb begin
    sel_word_c = '0;
    for (int k = 0; k < int'(CHANNELS); k++) begin
      if (chan_q == SEL_W'(k)) sel_word_c = channel_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Channel pointer, auto counter and snapshot next-state
  always_comb begin
    chan_d   = chan_q;
    auto_d   = auto_q;
    snap_d   = snap_q;
    mode_d   = mode_q;
    frozen_d = freeze;
    if (!freeze) begin
      mode_d = mode_auto;
      snap_d = sel_word_c;
      if (mode_auto) begin
        if (!mode_q) begin
          auto_d = '0;
        end else if (auto_q == AUTO_W'(AUTO_PERIOD - 1)) begin
          auto_d = '0;
          chan_d = (chan_q == SEL_W'(CHANNELS - 1)) ? '0 : chan_q + SEL_W'(1);
        end else begin
          auto_d = auto_q + AUTO_W'(1);
        end
      end else begin
        auto_d = '0;
        if (32'(select_in) < CHANNELS) chan_d = select_in;
      end
    end
  end

  // Display scan: prescaler and digit index keep running regardless of freeze
  always_comb begin
    pre_d = pre_q + PRE_W'(1);
    dig_d = dig_q;
    if (pre_q == PRE_W'(SCAN_DIV - 1)) begin
      pre_d = '0;
      dig_d = (dig_q == DIG_W'(DIGITS - 1)) ? '0 : dig_q + DIG_W'(1);
    end
  end

  // Select the nibble for the current digit and decide leading-zero blanking
  always_comb begin
    nibble_c = '0;
    for (int d = 0; d < int'(DIGITS); d++) begin
      if (dig_q == DIG_W'(d)) nibble_c = snap_q[d*4 +: 4];
    end
`ifdef MONITOR_LEADING_ZERO_BLANK_EN
    begin : g_lz
      logic [DIG_W-1:0] lead;
      lead = '0;
      for (int d = 0; d < int'(DIGITS); d++) begin
        if (snap_q[d*4 +: 4] != 4'h0) lead = DIG_W'(d);
      end
      lz_blank_c = (dig_q > lead);
    end
`else
    lz_blank_c = 1'b0;
`endif
    hex_c = hex7(nibble_c);
  end

  // Display drive, decoded purely from registers; blank slot on prescaler 0
  always_comb begin
    digit_enable = '0;
    segment_out  = 8'h00;
    if (pre_q != '0) begin
      digit_enable = DIGITS'(1) << dig_q;
      if (!lz_blank_c) segment_out[6:0] = hex_c;
      segment_out[7] = frozen_q && (dig_q == '0);
    end
  end

  assign channel_out = chan_q;
  assign frozen_out  = frozen_q;

  // State registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      chan_q   <= '0;
      snap_q   <= '0;
      pre_q    <= '0;
      dig_q    <= '0;
      auto_q   <= '0;
      frozen_q <= 1'b0;
      mode_q   <= 1'b0;
    end else begin
      chan_q   <= chan_d;
      snap_q   <= snap_d;
      pre_q    <= pre_d;
      dig_q    <= dig_d;
      auto_q   <= auto_d;
      frozen_q <= frozen_d;
      mode_q   <= mode_d;
    end
  end

endmodule

// File: tb/tb_multi_channel_monitor.sv
// Directed, table-driven bench for multi_channel_monitor
// (DATA_WIDTH=16, CHANNELS=4, SCAN_DIV=4, AUTO_PERIOD=8, plus a CHANNELS=3 copy).
module tb_multi_channel_monitor;

`ifdef MONITOR_LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] ch_data;
  logic [1:0]  sel;
  logic        mode_auto, freeze;
  logic [1:0]  ch_out;
  logic [3:0]  dig_en;
  logic [7:0]  seg;
  logic        frz_out;

  logic [47:0] ch_data3;
  logic [1:0]  sel3;
  logic [1:0]  ch_out3;
  logic [3:0]  dig_en3;
  logic [7:0]  seg3;
  logic        frz_out3;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  multi_channel_monitor #(
    .DATA_WIDTH(16), .CHANNELS(4), .SCAN_DIV(4), .AUTO_PERIOD(8)
  ) dut (
    .clock(clk), .reset(rst_n), .channel_data(ch_data), .select_in(sel),
    .mode_auto(mode_auto), .freeze(freeze), .channel_out(ch_out),
    .digit_enable(dig_en), .segment_out(seg), .frozen_out(frz_out)
  );

  multi_channel_monitor #(
    .DATA_WIDTH(16), .CHANNELS(3), .SCAN_DIV(4), .AUTO_PERIOD(8)
  ) dut3 (
    .clock(clk), .reset(rst_n), .channel_data(ch_data3), .select_in(sel3),
    .mode_auto(1'b0), .freeze(1'b0), .channel_out(ch_out3),
    .digit_enable(dig_en3), .segment_out(seg3), .frozen_out(frz_out3)
  );

  typedef struct {
    logic [15:0] word;
    logic [31:0] segs;  // digit d expected at segs[8*d +: 8]
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Observe one full scan; capture each digit's segments and verify blanking
  task automatic scan(output logic [31:0] segs, output logic blank_ok, output logic got_all);
    logic [3:0] got;
    segs = '0; got = '0; blank_ok = 1'b1;
    for (int c = 0; c < 40 && got != 4'hF; c++) begin
      @(negedge clk);
      case (dig_en)
        4'b0001: begin segs[7:0]   = seg; got[0] = 1'b1; end
        4'b0010: begin segs[15:8]  = seg; got[1] = 1'b1; end
        4'b0100: begin segs[23:16] = seg; got[2] = 1'b1; end
        4'b1000: begin segs[31:24] = seg; got[3] = 1'b1; end
        4'b0000: if (seg != 8'h00) blank_ok = 1'b0;
        default: blank_ok = 1'b0;
      endcase
    end
    got_all = (got == 4'hF);
  endtask

  task automatic scan_check(input string name, input logic [31:0] exp);
    logic [31:0] s;
    logic bok, gall;
    scan(s, bok, gall);
    check({name, " segs"}, s, exp);
    check({name, " blank"}, 32'(bok), 32'd1);
    check({name, " scan"}, 32'(gall), 32'd1);
  endtask

  initial begin
    vec_t vecs[7];
    logic [3:0] exp_en[9];
    vecs[0] = '{16'h1232, 32'h065B4F5B};
    vecs[1] = '{16'hA0C0, 32'h773F393F};
    vecs[2] = '{16'h0007, LZB ? 32'h00000007 : 32'h3F3F3F07};
    vecs[3] = '{16'h89EF, 32'h7F6F7971};
    vecs[4] = '{16'h4D56, 32'h665E6D7D};
    vecs[5] = '{16'h0000, LZB ? 32'h0000003F : 32'h3F3F3F3F};
    vecs[6] = '{16'h0100, LZB ? 32'h00063F3F : 32'h3F063F3F};
    exp_en = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h2, 4'h0};

    // Reset and scan start-up
    rst_n = 1'b0; mode_auto = 1'b0; freeze = 1'b0; sel = 2'd2; sel3 = 2'd2;
    ch_data  = {16'h1233, 16'h1232, 16'h1231, 16'h1230};
    ch_data3 = {16'h3332, 16'h3331, 16'h3330};
    step(3);
    check("rst chan", 32'(ch_out), 32'd0);
    check("rst en", 32'(dig_en), 32'd0);
    check("rst seg", 32'(seg), 32'd0);
    check("rst frozen", 32'(frz_out), 32'd0);
    rst_n = 1'b1;
    #1;
    check("post-rst en", 32'(dig_en), 32'd0);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      check($sformatf("en seq %0d", i), 32'(dig_en), 32'(exp_en[i]));
      if (i == 1) check("sel latency", 32'(ch_out), 32'd2);
      if (i == 3) check("first digit", 32'(seg), 32'h5B);
    end

    // Out-of-range select on the 3-channel copy holds the last valid channel
    check("ch3 valid", 32'(ch_out3), 32'd2);
    sel3 = 2'd3;
    step(3);
    check("ch3 out of range", 32'(ch_out3), 32'd2);

    // Auto cycling from channel 3 with wrap
    sel = 2'd3;
    step(2);
    check("manual 3", 32'(ch_out), 32'd3);
    mode_auto = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      @(negedge clk);
      check($sformatf("auto edge %0d", i), 32'(ch_out),
            (i < 8) ? 32'd3 : ((i < 16) ? 32'd0 : 32'd1));
    end
    // Freeze holds the channel in auto mode
    freeze = 1'b1;
    step(20);
    check("auto frozen", 32'(ch_out), 32'd1);
    freeze = 1'b0;
    mode_auto = 1'b0; sel = 2'd2;
    step(1);
    check("auto fall", 32'(ch_out), 32'd2);

    // Freeze holds snapshot and channel; dp shown on digit 0
    sel = 2'd1;
    step(3);
    freeze = 1'b1; sel = 2'd0; ch_data[31:16] = 16'hBEEF;
    step(3);
    check("freeze chan", 32'(ch_out), 32'd1);
    check("frozen_out", 32'(frz_out), 32'd1);
    scan_check("frozen", 32'h065B4F86);
    freeze = 1'b0;
    step(1);
    check("unfreeze chan", 32'(ch_out), 32'd0);
    step(1);
    scan_check("unfrozen", 32'h065B4F3F);

    // Table of snapshot words through channel 0
    for (int v = 0; v < 7; v++) begin
      ch_data[15:0] = vecs[v].word;
      sel = 2'd0;
      step(3);
      scan_check($sformatf("vec %0h", vecs[v].word), vecs[v].segs);
    end

    // Mid-scan reset returns to digit 0 with a blank first cycle
    step(2);
    rst_n = 1'b0;
    #1;
    check("midrst en", 32'(dig_en), 32'd0);
    check("midrst chan", 32'(ch_out), 32'd0);
    step(1);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst digit0", 32'(dig_en), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
